// File: rtl/ecc_if_pkg.sv
// Shared encodings and helpers for the ECC operand/scalar host interface.
package ecc_if_pkg;

    localparam logic [1:0] WR_SEL_OPERAND = 2'b00;
    localparam logic [1:0] WR_SEL_SCALAR  = 2'b01;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_CAP  = 2'd2,
        RD_OUT  = 2'd3
    } rd_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ecc_scalar_shifter.sv
// Scalar register with word-slot loading and DIGIT_W-bit left rotation
// feeding the ECC controller one digit per request.
module ecc_scalar_shifter
    import ecc_if_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DIGIT_W     = 1,
    parameter int SCALAR_SIZE = 385,
    parameter int SWORDS      = 13,
    parameter int SLOT_W      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic [SLOT_W-1:0]  slot_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic               req_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic [8:0]         digit_cnt_o,
    output logic               done_o
);

    localparam int NUM_DIGITS = ceil_div(SCALAR_SIZE, DIGIT_W);
    localparam int PAD_W      = NUM_DIGITS * DIGIT_W;
    localparam int SW_BITS    = SWORDS * DATA_W;
    localparam logic [SW_BITS-1:0] SC_MASK = {SW_BITS{1'b1}} >> (SW_BITS - SCALAR_SIZE);

    logic [SW_BITS-1:0] scalar_q, scalar_d;
    logic [PAD_W-1:0]   rot_q, rot_d;
    logic [8:0]         cnt_q, cnt_d;
    logic               done_q, done_d;

    // A load restarts the rotation from the freshly loaded value, so a
    // same-cycle digit request is intentionally lost.
    always_comb begin
        scalar_d = scalar_q;
        rot_d    = rot_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (load_i) begin
            scalar_d = scalar_q;
            scalar_d[int'(slot_i) * DATA_W +: DATA_W] = data_i;
            scalar_d = scalar_d & SC_MASK;
            rot_d    = PAD_W'(scalar_d[SCALAR_SIZE-1:0]) << (PAD_W - SCALAR_SIZE);
            cnt_d    = '0;
        end else if (req_i) begin
            rot_d = (rot_q << DIGIT_W) | (rot_q >> (PAD_W - DIGIT_W));
            if (cnt_q == 9'(NUM_DIGITS - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scalar_q <= '0;
            rot_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            scalar_q <= scalar_d;
            rot_q    <= rot_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign digit_o     = rot_q[PAD_W-1 -: DIGIT_W];
    assign digit_cnt_o = cnt_q;
    assign done_o      = done_q;

endmodule

// File: rtl/ecc_operand_if.sv
// Host-side operand/scalar interface: assembles operands for RAM port B,
// streams RAM words back to the host and hands the scalar to the controller.
module ecc_operand_if
    import ecc_if_pkg::*;
#(
    parameter int REG_SIZE    = 384,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int DIGIT_W     = 1,
    parameter int SCALAR_SIZE = REG_SIZE + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en_i,
    input  logic [1:0]          wr_sel_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                wr_clr_i,
    input  logic                rd_req_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    input  logic                rd_ack_i,
    output logic                rd_valid_o,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic                ram_we_o,
    output logic [REG_SIZE-1:0] ram_din_o,
    input  logic [REG_SIZE-1:0] ram_dout_i,
    input  logic                busy_i,
    input  logic                req_digit_i,
    output logic [DIGIT_W-1:0]  digit_o,
    output logic [8:0]          digit_cnt_o,
    output logic                scalar_done_o,
    output logic                err_o,
    input  logic                err_clr_i
);

    localparam int NUM_WORDS = ceil_div(REG_SIZE, DATA_W);
    localparam int SWORDS    = ceil_div(SCALAR_SIZE, DATA_W);
    localparam int OP_BITS   = NUM_WORDS * DATA_W;
    localparam int OP_PTR_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int SC_PTR_W  = (SWORDS > 1) ? $clog2(SWORDS) : 1;

    logic [OP_BITS-1:0]  op_buf_q, op_buf_d;
    logic [OP_PTR_W-1:0] op_ptr_q, op_ptr_d;
    logic [SC_PTR_W-1:0] sc_ptr_q, sc_ptr_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   commit_addr_q, commit_addr_d;
    logic                err_q, err_d;

    rd_state_e           state_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [OP_BITS-1:0]  rd_buf_q;
    logic [OP_PTR_W-1:0] rd_idx_q;
    logic                rd_valid_q;

    logic wr_op, wr_sc, op_last, rd_start, err_set;

    always_comb begin
        wr_op    = wr_en_i && !wr_clr_i && !busy_i && (wr_sel_i == WR_SEL_OPERAND);
        wr_sc    = wr_en_i && !wr_clr_i && !busy_i && (wr_sel_i == WR_SEL_SCALAR);
        op_last  = wr_op && (op_ptr_q == OP_PTR_W'(NUM_WORDS - 1));
        rd_start = (state_q == RD_IDLE) && rd_req_i && !busy_i && !ram_we_q;
        // Anything the host tries while the engine owns the RAM, or any
        // RAM activity of ours that busy_i cuts short, is flagged.
        err_set  = (wr_en_i && !wr_clr_i && busy_i)
                 || ((state_q == RD_IDLE) && rd_req_i && busy_i)
                 || ((state_q != RD_IDLE) && busy_i)
                 || (ram_we_q && busy_i);

        op_buf_d = op_buf_q;
        if (wr_op) begin
            op_buf_d[int'(op_ptr_q) * DATA_W +: DATA_W] = wr_data_i;
        end

        op_ptr_d = op_ptr_q;
        if (wr_clr_i) begin
            op_ptr_d = '0;
        end else if (wr_op) begin
            op_ptr_d = op_last ? '0 : op_ptr_q + 1'b1;
        end

        sc_ptr_d = sc_ptr_q;
        if (wr_clr_i) begin
            sc_ptr_d = '0;
        end else if (wr_sc) begin
            sc_ptr_d = (sc_ptr_q == SC_PTR_W'(SWORDS - 1)) ? '0 : sc_ptr_q + 1'b1;
        end

        ram_we_d      = op_last;
        commit_addr_d = op_last ? wr_addr_i : commit_addr_q;

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_buf_q      <= '0;
            op_ptr_q      <= '0;
            sc_ptr_q      <= '0;
            ram_we_q      <= 1'b0;
            commit_addr_q <= '0;
            err_q         <= 1'b0;
        end else begin
            op_buf_q      <= op_buf_d;
            op_ptr_q      <= op_ptr_d;
            sc_ptr_q      <= sc_ptr_d;
            ram_we_q      <= ram_we_d;
            commit_addr_q <= commit_addr_d;
            err_q         <= err_d;
        end
    end

    // Readback FSM; busy_i in any non-idle state abandons the read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RD_IDLE;
            rd_addr_q  <= '0;
            rd_buf_q   <= '0;
            rd_idx_q   <= '0;
            rd_valid_q <= 1'b0;
        end else if (busy_i && (state_q != RD_IDLE)) begin
            state_q    <= RD_IDLE;
            rd_idx_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (rd_start) begin
                        rd_addr_q <= rd_addr_i;
                        state_q   <= RD_ADDR;
                    end
                end
                RD_ADDR: state_q <= RD_CAP;
                RD_CAP: begin
                    rd_buf_q   <= OP_BITS'(ram_dout_i);
                    rd_idx_q   <= '0;
                    rd_valid_q <= 1'b1;
                    state_q    <= RD_OUT;
                end
                RD_OUT: begin
                    if (rd_ack_i) begin
                        if (rd_idx_q == OP_PTR_W'(NUM_WORDS - 1)) begin
                            rd_idx_q   <= '0;
                            rd_valid_q <= 1'b0;
                            state_q    <= RD_IDLE;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_addr_o = '0;
        if (!busy_i) begin
            if (ram_we_q) begin
                ram_addr_o = commit_addr_q;
            end else if (state_q == RD_ADDR) begin
                ram_addr_o = rd_addr_q;
            end
        end
    end

    assign ram_we_o   = ram_we_q && !busy_i;
    assign ram_din_o  = op_buf_q[REG_SIZE-1:0];
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_valid_q ? rd_buf_q[int'(rd_idx_q) * DATA_W +: DATA_W] : '0;
    assign err_o      = err_q;

    ecc_scalar_shifter #(
        .DATA_W      (DATA_W),
        .DIGIT_W     (DIGIT_W),
        .SCALAR_SIZE (SCALAR_SIZE),
        .SWORDS      (SWORDS),
        .SLOT_W      (SC_PTR_W)
    ) u_shifter (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (wr_sc),
        .slot_i      (sc_ptr_q),
        .data_i      (wr_data_i),
        .req_i       (req_digit_i),
        .digit_o     (digit_o),
        .digit_cnt_o (digit_cnt_o),
        .done_o      (scalar_done_o)
    );

endmodule

// File: tb/tb_ecc_operand_if.sv
// Scoreboard bench for ecc_operand_if: one instance per digit width, shared host stimulus.
module tb_ecc_operand_if;
    import ecc_if_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, wr_en, wr_clr, rd_req, rd_ack, busy, req1, req2, err_clr;
    logic [1:0]  wr_sel;
    logic [5:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [383:0] ram_dout;

    logic        rd_valid1, ram_we1, done1, err1;
    logic [31:0] rd_data1;
    logic [5:0]  ram_addr1;
    logic [383:0] ram_din1;
    logic [0:0]  digit1;
    logic [8:0]  cnt1;

    logic        rd_valid2, ram_we2, done2, err2;
    logic [31:0] rd_data2;
    logic [5:0]  ram_addr2;
    logic [383:0] ram_din2;
    logic [1:0]  digit2;
    logic [8:0]  cnt2;

    ecc_operand_if #(.DIGIT_W(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_clr_i(wr_clr),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_i(rd_ack),
        .rd_valid_o(rd_valid1), .rd_data_o(rd_data1), .ram_addr_o(ram_addr1),
        .ram_we_o(ram_we1), .ram_din_o(ram_din1), .ram_dout_i(ram_dout),
        .busy_i(busy), .req_digit_i(req1), .digit_o(digit1), .digit_cnt_o(cnt1),
        .scalar_done_o(done1), .err_o(err1), .err_clr_i(err_clr));

    ecc_operand_if #(.DIGIT_W(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_clr_i(wr_clr),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_i(rd_ack),
        .rd_valid_o(rd_valid2), .rd_data_o(rd_data2), .ram_addr_o(ram_addr2),
        .ram_we_o(ram_we2), .ram_din_o(ram_din2), .ram_dout_i(ram_dout),
        .busy_i(busy), .req_digit_i(req2), .digit_o(digit2), .digit_cnt_o(cnt2),
        .scalar_done_o(done2), .err_o(err2), .err_clr_i(err_clr));

    // Operand RAM port B model with one cycle read latency.
    logic [383:0] mem [0:63];
    always @(posedge clk) begin
        if (ram_we1) mem[ram_addr1] <= ram_din1;
        ram_dout <= mem[ram_addr1];
    end

    int total = 0;
    int bad   = 0;

    logic [389:0] we_exp [$];
    logic [31:0]  rd_exp [$];
    logic [0:0]   d1_exp [$];
    logic [1:0]   d2_exp [$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: output seen with no expected entry", name);
    endtask

    // Monitor: pops expectations whenever the DUT presents a transfer.
    always @(negedge clk) begin
        logic [389:0] e;
        if (reset_n) begin
            if (ram_we1) begin
                if (we_exp.size() == 0) unexpected("ram_we");
                else begin
                    e = we_exp.pop_front();
                    chk("ram_addr", 512'(ram_addr1), 512'(e[389:384]));
                    chk("ram_din", 512'(ram_din1), 512'(e[383:0]));
                end
            end
            if (rd_valid1 && rd_ack) begin
                if (rd_exp.size() == 0) unexpected("rd_data");
                else chk("rd_data", 512'(rd_data1), 512'(rd_exp.pop_front()));
            end
            if (req1) begin
                if (d1_exp.size() == 0) unexpected("digit1");
                else chk("digit1", 512'(digit1), 512'(d1_exp.pop_front()));
            end
            if (req2) begin
                if (d2_exp.size() == 0) unexpected("digit2");
                else chk("digit2", 512'(digit2), 512'(d2_exp.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_valid"}, 512'(rd_valid1), 512'(0));
        chk({tag, "_rd_data"}, 512'(rd_data1), 512'(0));
        chk({tag, "_ram_we"}, 512'(ram_we1), 512'(0));
        chk({tag, "_ram_addr"}, 512'(ram_addr1), 512'(0));
        chk({tag, "_ram_din"}, 512'(ram_din1), 512'(0));
        chk({tag, "_digit"}, 512'(digit1), 512'(0));
        chk({tag, "_cnt"}, 512'(cnt1), 512'(0));
        chk({tag, "_done"}, 512'(done1), 512'(0));
        chk({tag, "_err"}, 512'(err1), 512'(0));
    endtask

    task automatic start_read(input logic [5:0] a);
        rd_req = 1'b1; rd_addr = a;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [383:0] din;
        reset_n = 1'b0; wr_en = 1'b0; wr_clr = 1'b0; rd_req = 1'b0; rd_ack = 1'b0;
        busy = 1'b0; req1 = 1'b0; req2 = 1'b0; err_clr = 1'b0;
        wr_sel = WR_SEL_OPERAND; wr_addr = '0; rd_addr = '0; wr_data = '0;
        tick(); tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick();

        // Operand 0x0..0xB committed to address 5.
        for (int i = 0; i < 12; i++) din[i*32 +: 32] = 32'(i);
        we_exp.push_back({6'd5, din});
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_sel = WR_SEL_OPERAND; wr_addr = 6'd5; wr_data = 32'(i);
            tick();
            if (i == 10) chk("we_before_last", 512'(ram_we1), 512'(0));
        end
        wr_en = 1'b0;
        chk("we_after_last", 512'(ram_we1), 512'(1));
        chk("we_top_word", 512'(ram_din1[383:352]), 512'(32'hB));
        tick();
        chk("we_single_pulse", 512'(ram_we1), 512'(0));

        // Readback of address 5.
        for (int i = 0; i < 12; i++) rd_exp.push_back(32'(i));
        rd_req = 1'b1; rd_addr = 6'd5;
        tick();
        rd_req = 1'b0;
        chk("rd_valid_c1", 512'(rd_valid1), 512'(0));
        tick();
        chk("rd_valid_c2", 512'(rd_valid1), 512'(0));
        tick();
        chk("rd_valid_c3", 512'(rd_valid1), 512'(1));
        rd_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 10) chk("rd_valid_before_last", 512'(rd_valid1), 512'(1));
        end
        rd_ack = 1'b0;
        chk("rd_valid_after_last", 512'(rd_valid1), 512'(0));

        // Host access while busy; then a simultaneous set and clear.
        busy = 1'b1; wr_en = 1'b1; wr_sel = WR_SEL_OPERAND; wr_data = 32'hBAD0; rd_req = 1'b1;
        tick();
        chk("busy_no_we", 512'(ram_we1), 512'(0));
        chk("busy_err_set", 512'(err1), 512'(1));
        rd_req = 1'b0; err_clr = 1'b1;
        tick();
        chk("err_set_beats_clr", 512'(err1), 512'(1));
        busy = 1'b0; wr_en = 1'b0;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", 512'(err1), 512'(0));
        tick();
        chk("busy_rd_rejected", 512'(rd_valid1), 512'(0));

        // Commit pending when busy rises is dropped.
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_sel = WR_SEL_OPERAND; wr_addr = 6'd7; wr_data = 32'hA0 + 32'(i);
            tick();
            if (i == 10) chk("drop_we_before_last", 512'(ram_we1), 512'(0));
        end
        wr_en = 1'b0; busy = 1'b1;
        #1;
        chk("drop_we_gated", 512'(ram_we1), 512'(0));
        chk("drop_addr_gated", 512'(ram_addr1), 512'(0));
        tick();
        chk("drop_err", 512'(err1), 512'(1));
        busy = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("drop_err_cleared", 512'(err1), 512'(0));

        // wr_clr wins over a same-cycle write and restarts assembly.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_sel = WR_SEL_OPERAND; wr_data = 32'hDEAD;
            tick();
        end
        wr_clr = 1'b1; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_clr = 1'b0;
        for (int i = 0; i < 12; i++) din[i*32 +: 32] = 32'h100 + 32'(i);
        we_exp.push_back({6'd9, din});
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h100 + 32'(i);
            tick();
            if (i == 10) chk("clr_we_before_last", 512'(ram_we1), 512'(0));
        end
        wr_en = 1'b0;
        chk("clr_we_after_last", 512'(ram_we1), 512'(1));
        tick();

        // Scalar 385'h1_00..01; top word carries junk above bit 384.
        for (int i = 0; i < 13; i++) begin
            wr_en = 1'b1; wr_sel = WR_SEL_SCALAR;
            wr_data = (i == 0) ? 32'h1 : ((i == 12) ? 32'hFFFF_FFFF : 32'h0);
            tick();
        end
        wr_en = 1'b0; wr_sel = WR_SEL_OPERAND;
        chk("sc_first_digit1", 512'(digit1), 512'(1));
        chk("sc_first_digit2", 512'(digit2), 512'(2'b10));
        for (int k = 0; k < 385; k++) d1_exp.push_back((k == 0 || k == 384) ? 1'b1 : 1'b0);
        for (int k = 0; k < 193; k++) d2_exp.push_back((k == 0 || k == 192) ? 2'b10 : 2'b00);
        for (int k = 0; k < 385; k++) begin
            req1 = 1'b1; req2 = (k < 193);
            tick();
            if (k == 0) chk("sc_cnt_one", 512'(cnt1), 512'(1));
            if (k == 191) chk("sc_done2_early", 512'(done2), 512'(0));
            if (k == 192) begin
                chk("sc_done2", 512'(done2), 512'(1));
                chk("sc_cnt2_wrap", 512'(cnt2), 512'(0));
            end
            if (k == 383) chk("sc_done1_early", 512'(done1), 512'(0));
            if (k == 384) chk("sc_done1", 512'(done1), 512'(1));
        end
        req1 = 1'b0; req2 = 1'b0;
        chk("sc_cnt1_wrap", 512'(cnt1), 512'(0));
        tick();
        chk("sc_done1_pulse", 512'(done1), 512'(0));
        chk("sc_digit1_restored", 512'(digit1), 512'(1));
        chk("sc_digit2_restored", 512'(digit2), 512'(2'b10));

        // Scalar write beats a same-cycle digit request.
        d1_exp.push_back(1'b1); d1_exp.push_back(1'b0); d1_exp.push_back(1'b0);
        req1 = 1'b1;
        tick(); tick(); tick();
        chk("sc_cnt_three", 512'(cnt1), 512'(3));
        d1_exp.push_back(1'b0);
        wr_en = 1'b1; wr_sel = WR_SEL_SCALAR; wr_data = 32'h1;
        tick();
        wr_en = 1'b0; wr_sel = WR_SEL_OPERAND; req1 = 1'b0;
        chk("sc_write_wins_cnt", 512'(cnt1), 512'(0));
        chk("sc_write_wins_digit", 512'(digit1), 512'(1));

        // busy rising while words are being handed out.
        rd_exp.push_back(32'h0);
        start_read(6'd5);
        chk("abort_valid_before", 512'(rd_valid1), 512'(1));
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0; busy = 1'b1;
        tick();
        chk("abort_valid", 512'(rd_valid1), 512'(0));
        chk("abort_err", 512'(err1), 512'(1));
        busy = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset in the middle of a read with err and digit state live.
        busy = 1'b1; wr_en = 1'b1;
        tick();
        busy = 1'b0; wr_en = 1'b0;
        req1 = 1'b1; d1_exp.push_back(1'b1);
        tick();
        req1 = 1'b0;
        start_read(6'd9);
        chk("rst_pre_valid", 512'(rd_valid1), 512'(1));
        chk("rst_pre_err", 512'(err1), 512'(1));
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        tick();
        reset_n = 1'b1;
        tick();

        chk("we_queue_drained", 512'(we_exp.size()), 512'(0));
        chk("rd_queue_drained", 512'(rd_exp.size()), 512'(0));
        chk("d1_queue_drained", 512'(d1_exp.size()), 512'(0));
        chk("d2_queue_drained", 512'(d2_exp.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
